rgb_pixel_assembler: RTL and testbench

Byte-serial front end for the colorspace path. Receives an 8-bit subpixel stream in R, G, B order and assembles full 24-bit pixels. Presents the pixels through a valid/ready output stage to the grayscale converter. Supports frame resynchronisation and counts delivered pixels.

---
 rtl/rgb_pixel_assembler.sv | 119 +++++++++++
 tb/tb_rgb_pixel_assembler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_assembler.sv
// rgb_pixel_assembler: collects an R, G, B subpixel stream into full pixels,
// presents them through a one-entry valid/ready output stage and counts the
// pixels delivered since reset or the last start-of-frame.
//
// Handshake semantics (both ports): a beat moves on a rising edge where valid
// and ready are both high; the sender holds data stable while valid is high
// and ready is low; ready may depend combinationally on the far side's ready.
module rgb_pixel_assembler #(
  parameter int P_PIXEL_DEPTH = 24,  // must be a multiple of 3
  parameter int P_COUNT_WIDTH = 16
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic [P_PIXEL_DEPTH/3-1:0] I_SUBPIXEL,
  input  logic                       I_SUBPIXEL_VALID,
  output logic                       O_SUBPIXEL_READY,
  input  logic                       I_SOF,
  output logic [P_PIXEL_DEPTH-1:0]   O_PIXEL,
  output logic                       O_PIXEL_VALID,
  input  logic                       I_PIXEL_READY,
  output logic [P_COUNT_WIDTH-1:0]   O_PIXEL_COUNT,
  output logic [1:0]                 O_BYTE_INDEX   // debug view of the byte-index FSM
);

  localparam int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3;

  typedef enum logic [1:0] {
    S_R = 2'd0,
    S_G = 2'd1,
    S_B = 2'd2
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [P_SUBPIXEL_DEPTH-1:0] r_q;
  logic [P_SUBPIXEL_DEPTH-1:0] g_q;
  logic [P_SUBPIXEL_DEPTH-1:0] r_next;
  logic [P_SUBPIXEL_DEPTH-1:0] g_next;
  logic                        accept;
  logic                        xfer;
  logic                        load;

  // Only the completing B byte needs a free output slot; a slot that is
  // draining this cycle counts as free, which keeps one subpixel per cycle.
  assign O_SUBPIXEL_READY = (state != S_B) || !O_PIXEL_VALID || I_PIXEL_READY;
  assign accept           = I_SUBPIXEL_VALID && O_SUBPIXEL_READY;
  assign xfer             = O_PIXEL_VALID && I_PIXEL_READY;
  assign O_BYTE_INDEX     = state;

  // Next byte index and partial R/G; SOF restarts the pixel, and a byte
  // accepted alongside SOF becomes the new pixel's R.
  always_comb begin
    state_next = state;
    r_next     = r_q;
    g_next     = g_q;
    load       = 1'b0;
    if (I_SOF) begin
      r_next     = '0;
      g_next     = '0;
      state_next = S_R;
      if (accept) begin
        r_next     = I_SUBPIXEL;
        state_next = S_G;
      end
    end else if (accept) begin
      case (state)
        S_R: begin
          r_next     = I_SUBPIXEL;
          state_next = S_G;
        end
        S_G: begin
          g_next     = I_SUBPIXEL;
          state_next = S_B;
        end
        S_B: begin
          load       = 1'b1;
          state_next = S_R;
        end
        default: state_next = S_R;
      endcase
    end
  end

  // Byte-index state and partial R/G holding registers.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state <= S_R;
      r_q   <= '0;
      g_q   <= '0;
    end else begin
      state <= state_next;
      r_q   <= r_next;
      g_q   <= g_next;
    end
  end

  // Output slot: a load wins over a drain so back-to-back pixels keep valid high.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_PIXEL       <= '0;
      O_PIXEL_VALID <= 1'b0;
    end else if (load) begin
      O_PIXEL       <= {r_q, g_q, I_SUBPIXEL};
      O_PIXEL_VALID <= 1'b1;
    end else if (xfer) begin
      O_PIXEL_VALID <= 1'b0;
    end
  end

  // Delivered-pixel counter; SOF clears it and swallows a same-cycle transfer.
  always_ff @(posedge I_CLK) begin
    if (I_RESET || I_SOF) begin
      O_PIXEL_COUNT <= '0;
    end else if (xfer) begin
      O_PIXEL_COUNT <= O_PIXEL_COUNT + P_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rgb_pixel_assembler.sv
// tb_rgb_pixel_assembler: table-driven directed sequences, a counter-wrap
// sequence on a 4-bit-counter instance, and a randomized run, all checked
// against a pixel-level reference model and an expected-pixel queue.
module tb_rgb_pixel_assembler;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sub;
  logic        sub_valid;
  logic        sof;
  logic        pix_ready;

  logic        sub_ready,  sub_ready4;
  logic [23:0] pixel,      pixel4;
  logic        pix_valid,  pix_valid4;
  logic [15:0] count;
  logic [3:0]  count4;
  logic [1:0]  idx,        idx4;

  always #5 clk = ~clk;

  rgb_pixel_assembler #(.P_PIXEL_DEPTH(24), .P_COUNT_WIDTH(16)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_SUBPIXEL(sub), .I_SUBPIXEL_VALID(sub_valid),
    .O_SUBPIXEL_READY(sub_ready), .I_SOF(sof), .O_PIXEL(pixel),
    .O_PIXEL_VALID(pix_valid), .I_PIXEL_READY(pix_ready),
    .O_PIXEL_COUNT(count), .O_BYTE_INDEX(idx)
  );

  rgb_pixel_assembler #(.P_PIXEL_DEPTH(24), .P_COUNT_WIDTH(4)) dut4 (
    .I_CLK(clk), .I_RESET(rst), .I_SUBPIXEL(sub), .I_SUBPIXEL_VALID(sub_valid),
    .O_SUBPIXEL_READY(sub_ready4), .I_SOF(sof), .O_PIXEL(pixel4),
    .O_PIXEL_VALID(pix_valid4), .I_PIXEL_READY(pix_ready),
    .O_PIXEL_COUNT(count4), .O_BYTE_INDEX(idx4)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  // ---------------- reference model and scoreboard ----------------
  // The model thinks in pixels: a list of bytes collected so far for the
  // current pixel, one pending output pixel, and a delivered count.
  logic [7:0]  part[$];
  logic        m_vld;
  logic [23:0] m_pix;
  int          m_cnt;
  logic [23:0] exp_q[$];
  bit          model_on = 1'b0;

  function automatic logic exp_ready(input logic pr);
    return !(part.size() == 2 && m_vld && !pr);
  endfunction

  typedef struct {
    logic        rst, v;
    logic [7:0]  b;
    logic        sof, pr;
    logic        chk, pc;
    logic        e_rdy, e_vld;
    logic [23:0] e_pix;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, v, input logic [7:0] b, input logic s, pr);
    vec_t t;
    t.rst = r; t.v = v; t.b = b; t.sof = s; t.pr = pr;
    t.chk = 1'b0; t.pc = 1'b0; t.e_rdy = 1'b0; t.e_vld = 1'b0; t.e_pix = '0; t.e_cnt = 0;
    return t;
  endfunction

  task automatic add(input logic r, v, input logic [7:0] b, input logic s, pr,
                     input logic c, pc, er, ev, input logic [23:0] ep, input int ec);
    vec_t t;
    t = mk(r, v, b, s, pr);
    t.chk = c; t.pc = pc; t.e_rdy = er; t.e_vld = ev; t.e_pix = ep; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic model_check();
    logic er;
    er = exp_ready(pix_ready);
    chk("model_ready",  {31'd0, sub_ready},  {31'd0, er});
    chk("model_ready4", {31'd0, sub_ready4}, {31'd0, er});
    chk("model_valid",  {31'd0, pix_valid},  {31'd0, m_vld});
    chk("model_valid4", {31'd0, pix_valid4}, {31'd0, m_vld});
    if (m_vld) begin
      chk("model_pixel",  {8'd0, pixel},  {8'd0, m_pix});
      chk("model_pixel4", {8'd0, pixel4}, {8'd0, m_pix});
    end
    chk("model_count",  {16'd0, count},  32'(m_cnt % 65536));
    chk("model_count4", {28'd0, count4}, 32'(m_cnt % 16));
    chk("model_index",  {30'd0, idx},    32'(part.size()));
    chk("model_index4", {30'd0, idx4},   32'(part.size()));
  endtask

  task automatic model_update(input vec_t t);
    logic acc;
    if (t.rst) begin
      part.delete(); m_vld = 1'b0; m_pix = '0; m_cnt = 0; exp_q.delete();
      return;
    end
    acc = t.v && exp_ready(t.pr);
    if (m_vld && t.pr) begin
      m_vld = 1'b0;
      m_cnt = t.sof ? 0 : (m_cnt + 1) % 65536;
    end
    if (t.sof) begin
      part.delete();
      m_cnt = 0;
    end
    if (acc) begin
      part.push_back(t.b);
      if (part.size() == 3) begin
        m_pix = {part[0], part[1], part[2]};
        m_vld = 1'b1;
        exp_q.push_back(m_pix);
        part.delete();
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle of inputs, checks at the
  // falling edge, advances the model, and returns just after the next edge.
  task automatic step(input vec_t t, input string tag);
    rst = t.rst; sub_valid = t.v; sub = t.b; sof = t.sof; pix_ready = t.pr;
    @(negedge clk);
    if (model_on) begin
      model_check();
      if (!t.rst && pix_valid && t.pr) begin
        if (exp_q.size() == 0) chk("sb_unexpected_pixel", {8'd0, pixel}, 32'hFFFF_FFFF);
        else chk("sb_pixel", {8'd0, pixel}, {8'd0, exp_q.pop_front()});
      end
    end
    if (t.chk) begin
      chk({tag, "_ready"}, {31'd0, sub_ready}, {31'd0, t.e_rdy});
      chk({tag, "_valid"}, {31'd0, pix_valid}, {31'd0, t.e_vld});
      chk({tag, "_count"}, {16'd0, count},     32'(t.e_cnt));
      if (t.pc) chk({tag, "_pixel"}, {8'd0, pixel}, {8'd0, t.e_pix});
    end
    model_update(t);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; sub_valid = 1'b0; sub = '0; sof = 1'b0; pix_ready = 1'b0;
    @(posedge clk); #1;
    step(mk(1, 0, 8'h00, 0, 0), "reset");
    model_on = 1'b1;
    step(mk(1, 0, 8'h00, 0, 0), "reset");

    chk("reset_pixel", {8'd0, pixel},     32'd0);
    chk("reset_valid", {31'd0, pix_valid}, 32'd0);
    chk("reset_count", {16'd0, count},    32'd0);
    chk("reset_ready", {31'd0, sub_ready}, 32'd1);
    chk("reset_index", {30'd0, idx},      32'd0);

    // FF,7F,00 -> FF7F00 valid for one cycle
    add(0,1,8'hFF,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h7F,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h00,0,1, 1,0,1,0,24'h0,0);
    add(0,0,8'h00,0,1, 1,1,1,1,24'hFF7F00,0);
    add(0,0,8'h00,0,1, 1,0,1,0,24'h0,1);
    // SOF clears the count, then stream 01..09 at full rate
    add(0,0,8'h00,1,1, 1,0,1,0,24'h0,1);
    add(0,1,8'h01,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h02,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h03,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h04,0,1, 1,1,1,1,24'h010203,0);
    add(0,1,8'h05,0,1, 1,0,1,0,24'h0,1);
    add(0,1,8'h06,0,1, 1,0,1,0,24'h0,1);
    add(0,1,8'h07,0,1, 1,1,1,1,24'h040506,1);
    add(0,1,8'h08,0,1, 1,0,1,0,24'h0,2);
    add(0,1,8'h09,0,1, 1,0,1,0,24'h0,2);
    add(0,0,8'h00,0,1, 1,1,1,1,24'h070809,2);
    add(0,0,8'h00,0,1, 1,0,1,0,24'h0,3);
    // Backpressure: AABBCC pending, 11/22 accepted, 33 stalls until ready
    add(0,1,8'hAA,0,0, 1,0,1,0,24'h0,3);
    add(0,1,8'hBB,0,0, 1,0,1,0,24'h0,3);
    add(0,1,8'hCC,0,0, 1,0,1,0,24'h0,3);
    add(0,1,8'h11,0,0, 1,1,1,1,24'hAABBCC,3);
    add(0,1,8'h22,0,0, 1,1,1,1,24'hAABBCC,3);
    add(0,1,8'h33,0,0, 1,1,0,1,24'hAABBCC,3);
    add(0,1,8'h33,0,0, 1,1,0,1,24'hAABBCC,3);
    add(0,1,8'h33,0,1, 1,1,1,1,24'hAABBCC,3);
    add(0,0,8'h00,0,0, 1,1,1,1,24'h112233,4);
    add(0,0,8'h00,0,1, 1,1,1,1,24'h112233,4);
    add(0,0,8'h00,0,1, 1,0,1,0,24'h0,5);
    // SOF with a same-cycle byte: 12,34 discarded, 56 becomes R
    add(0,1,8'h12,0,1, 1,0,1,0,24'h0,5);
    add(0,1,8'h34,0,1, 1,0,1,0,24'h0,5);
    add(0,1,8'h56,1,1, 1,0,1,0,24'h0,5);
    add(0,1,8'h78,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h9A,0,1, 1,0,1,0,24'h0,0);
    add(0,0,8'h00,0,1, 1,1,1,1,24'h56789A,0);
    add(0,0,8'h00,0,1, 1,0,1,0,24'h0,1);
    // Reset with a pending pixel and a partial 01,02
    add(0,1,8'hA1,0,0, 1,0,1,0,24'h0,1);
    add(0,1,8'hB2,0,0, 1,0,1,0,24'h0,1);
    add(0,1,8'hC3,0,0, 1,0,1,0,24'h0,1);
    add(0,1,8'h01,0,0, 1,1,1,1,24'hA1B2C3,1);
    add(0,1,8'h02,0,0, 1,1,1,1,24'hA1B2C3,1);
    add(1,0,8'h00,0,0, 1,1,0,1,24'hA1B2C3,1);
    add(0,0,8'h00,0,0, 1,1,1,0,24'h0,0);
    add(0,1,8'h03,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h04,0,1, 1,0,1,0,24'h0,0);
    add(0,1,8'h05,0,1, 1,0,1,0,24'h0,0);
    add(0,0,8'h00,0,1, 1,1,1,1,24'h030405,0);
    add(0,0,8'h00,0,1, 1,0,1,0,24'h0,1);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Counter wrap on the 4-bit instance: 17 pixels after a SOF
    step(mk(0, 0, 8'h00, 1, 1), "wrap_sof");
    for (int p = 1; p <= 17; p++) begin
      for (int k = 0; k < 3; k++) step(mk(0, 1, 8'($urandom_range(0, 255)), 0, 1), "wrap");
      step(mk(0, 0, 8'h00, 0, 1), "wrap_idle");
      if (p == 15) chk("wrap_count4_15", {28'd0, count4}, 32'd15);
      if (p == 16) chk("wrap_count4_16", {28'd0, count4}, 32'd0);
      if (p == 17) begin
        chk("wrap_count4_17", {28'd0, count4}, 32'd1);
        chk("wrap_count16_17", {16'd0, count}, 32'd17);
      end
    end

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      vec_t t;
      t = mk($urandom_range(0, 199) == 0,
             $urandom_range(0, 9) < 7,
             8'($urandom_range(0, 255)),
             $urandom_range(0, 49) == 0,
             $urandom_range(0, 9) < 6);
      step(t, "rand");
    end

    // Drain whatever is still pending
    for (int n = 0; n < 4; n++) step(mk(0, 0, 8'h00, 0, 1), "drain");
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
